// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter that shares one FIFO write port among NUM_REQ valid/ready requesters.
// Each owner keeps the port for at most MAX_BURST beats. The FIFO is never written while it reports full.
module fifo_write_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]    req_data,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic                         fifo_full,
  output logic                         fifo_write_enable,
  output logic [DATA_W-1:0]            fifo_data_in,
  output logic [$clog2(NUM_REQ)-1:0]   grant_id,
  output logic                         busy
);

  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(MAX_BURST + 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t            state_q, state_d;
  logic [ID_W-1:0]   owner_q, owner_d;
  logic [ID_W-1:0]   last_owner_q, last_owner_d;
  logic [CNT_W-1:0]  beat_cnt_q, beat_cnt_d;

  logic [ID_W-1:0]   pick;
  logic              any_valid;
  logic              owner_valid;
  logic              grant_ready;
  logic              xfer;
  logic              last_beat;

  // Rotating priority: the search starts just after the previous owner.
  always_comb begin
    int  idx;
    logic found;
    pick  = last_owner_q;
    found = 1'b0;
    idx   = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(last_owner_q) + k) % NUM_REQ;
      if (!found && req_valid[idx]) begin
        pick  = ID_W'(idx);
        found = 1'b1;
      end
    end
  end

  assign any_valid   = |req_valid;
  assign owner_valid = req_valid[owner_q];
  assign grant_ready = (state_q == GRANT) && !fifo_full;
  assign xfer        = owner_valid && grant_ready;
  assign last_beat   = (beat_cnt_q == CNT_W'(MAX_BURST - 1));

  always_comb begin
    req_ready = '0;
    if (grant_ready) begin
      req_ready[owner_q] = 1'b1;
    end
  end

  assign fifo_write_enable = xfer;
  assign fifo_data_in      = xfer ? req_data[int'(owner_q)*DATA_W +: DATA_W] : '0;
  assign grant_id          = owner_q;
  assign busy              = (state_q == GRANT);

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    beat_cnt_d   = beat_cnt_q;
    case (state_q)
      IDLE: begin
        if (any_valid) begin
          state_d      = GRANT;
          owner_d      = pick;
          last_owner_d = pick;
          beat_cnt_d   = '0;
        end
      end
      GRANT: begin
        if (xfer) begin
          if (last_beat) begin
            state_d    = IDLE;
            beat_cnt_d = '0;
          end else begin
            beat_cnt_d = beat_cnt_q + 1'b1;
          end
        end else if (!fifo_full && !owner_valid) begin
          // A full stall freezes the grant; only an idle owner gives it up.
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      owner_q      <= '0;
      last_owner_q <= ID_W'(NUM_REQ - 1);
      beat_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      beat_cnt_q   <= beat_cnt_d;
    end
  end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Scoreboard bench for fifo_write_arbiter: each scenario queues its expected per-cycle outputs,
// then pops and compares them as the DUT runs, while queue-backed requesters model the valid/ready streams.
module tb_fifo_write_arbiter;

  localparam int NUM_REQ   = 4;
  localparam int DATA_W    = 8;
  localparam int MAX_BURST = 4;

  logic                       clk = 1'b0;
  logic                       rst;
  logic [NUM_REQ-1:0]         req_valid;
  logic [NUM_REQ*DATA_W-1:0]  req_data;
  logic [NUM_REQ-1:0]         req_ready;
  logic                       fifo_full;
  logic                       fifo_write_enable;
  logic [DATA_W-1:0]          fifo_data_in;
  logic [1:0]                 grant_id;
  logic                       busy;

  typedef struct packed {
    logic       busy;
    logic       we;
    logic [7:0] data;
    logic [1:0] gid;
    logic [3:0] ready;
  } obs_t;

  int         checks   = 0;
  int         failures = 0;
  logic [7:0] rq [NUM_REQ][$];
  obs_t       exp_q [$];
  obs_t       obs;
  obs_t       e;

  always #5 clk = ~clk;

  fifo_write_arbiter #(
    .NUM_REQ  (NUM_REQ),
    .DATA_W   (DATA_W),
    .MAX_BURST(MAX_BURST)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .req_valid        (req_valid),
    .req_data         (req_data),
    .req_ready        (req_ready),
    .fifo_full        (fifo_full),
    .fifo_write_enable(fifo_write_enable),
    .fifo_data_in     (fifo_data_in),
    .grant_id         (grant_id),
    .busy             (busy)
  );

  function automatic string fmt(obs_t o);
    return $sformatf("busy=%b we=%b data=%h gid=%0d ready=%b", o.busy, o.we, o.data, o.gid, o.ready);
  endfunction

  function automatic void ex(logic b, logic w, logic [7:0] d, logic [1:0] g, logic [3:0] r);
    obs_t t;
    t.busy  = b;
    t.we    = w;
    t.data  = d;
    t.gid   = g;
    t.ready = r;
    exp_q.push_back(t);
  endfunction

  task automatic drive_req();
    for (int i = 0; i < NUM_REQ; i++) begin
      req_valid[i] = (rq[i].size() != 0);
      req_data[i*DATA_W +: DATA_W] = (rq[i].size() != 0) ? rq[i][0] : 8'h00;
    end
  endtask

  function automatic obs_t sample();
    return {busy, fifo_write_enable, fifo_data_in, grant_id, req_ready};
  endfunction

  // One clock: sample outputs mid-cycle, then retire whatever beat was accepted at the edge.
  task automatic step();
    logic [NUM_REQ-1:0] acc;
    @(negedge clk);
    obs = sample();
    acc = req_valid & req_ready;
    if (fifo_write_enable)
      $display("write id=%0d data=%h", grant_id, fifo_data_in);
    @(posedge clk);
    #1;
    for (int i = 0; i < NUM_REQ; i++)
      if (acc[i]) void'(rq[i].pop_front());
    drive_req();
  endtask

  task automatic do_reset();
    rst       = 1'b0;
    fifo_full = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) rq[i].delete();
    exp_q.delete();
    drive_req();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst       = 1'b0;
    fifo_full = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) rq[i].delete();
    rq[1].push_back(8'h99);
    drive_req();
    repeat (2) @(posedge clk);
    #1;
    obs = sample();
    checks++;
    if (obs !== obs_t'(0)) begin
      failures++;
      $display("FAIL reset_outputs: got %s, expected all zero", fmt(obs));
    end
    rst = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) rq[i].delete();
    drive_req();
    ex(0, 0, 8'h00, 2'd0, 4'b0000);
    ex(0, 0, 8'h00, 2'd0, 4'b0000);
    while (exp_q.size() != 0) begin
      step();
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL reset_idle: got %s, expected %s", fmt(obs), fmt(e));
      end
    end
  endtask

  task automatic test_single_burst();
    do_reset();
    for (int k = 0; k < 6; k++) rq[2].push_back(8'(8'h10 + k));
    drive_req();
    ex(0, 0, 8'h00, 2'd0, 4'b0000);
    for (int k = 0; k < 4; k++) ex(1, 1, 8'(8'h10 + k), 2'd2, 4'b0100);
    ex(0, 0, 8'h00, 2'd2, 4'b0000);
    ex(1, 1, 8'h14, 2'd2, 4'b0100);
    ex(1, 1, 8'h15, 2'd2, 4'b0100);
    ex(1, 0, 8'h00, 2'd2, 4'b0100);
    ex(0, 0, 8'h00, 2'd2, 4'b0000);
    while (exp_q.size() != 0) begin
      step();
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL single_burst: got %s, expected %s", fmt(obs), fmt(e));
      end
    end
  endtask

  task automatic test_round_robin();
    int order [5] = '{0, 1, 2, 3, 0};
    do_reset();
    for (int i = 0; i < NUM_REQ; i++)
      for (int k = 0; k < 8; k++) rq[i].push_back(8'(8'hA0 + i));
    drive_req();
    ex(0, 0, 8'h00, 2'd0, 4'b0000);
    foreach (order[n]) begin
      for (int k = 0; k < MAX_BURST; k++)
        ex(1, 1, 8'(8'hA0 + order[n]), 2'(order[n]), 4'(1 << order[n]));
      ex(0, 0, 8'h00, 2'(order[n]), 4'b0000);
    end
    while (exp_q.size() != 0) begin
      step();
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL round_robin: got %s, expected %s", fmt(obs), fmt(e));
      end
    end
  endtask

  task automatic test_full_stall();
    do_reset();
    for (int k = 0; k < 4; k++) rq[1].push_back(8'(8'h30 + k));
    drive_req();
    for (int phase = 0; phase < 3; phase++) begin
      if (phase == 0) begin
        ex(0, 0, 8'h00, 2'd0, 4'b0000);
        ex(1, 1, 8'h30, 2'd1, 4'b0010);
        ex(1, 1, 8'h31, 2'd1, 4'b0010);
      end else if (phase == 1) begin
        fifo_full = 1'b1;
        repeat (3) ex(1, 0, 8'h00, 2'd1, 4'b0000);
      end else begin
        fifo_full = 1'b0;
        ex(1, 1, 8'h32, 2'd1, 4'b0010);
        ex(1, 1, 8'h33, 2'd1, 4'b0010);
        ex(0, 0, 8'h00, 2'd1, 4'b0000);
      end
      while (exp_q.size() != 0) begin
        step();
        e = exp_q.pop_front();
        checks++;
        if (obs !== e) begin
          failures++;
          $display("FAIL full_stall: got %s, expected %s", fmt(obs), fmt(e));
        end
      end
    end
  endtask

  task automatic test_early_release();
    do_reset();
    rq[3].push_back(8'h55);
    drive_req();
    ex(0, 0, 8'h00, 2'd0, 4'b0000);
    for (int phase = 0; phase < 2; phase++) begin
      if (phase == 1) begin
        rq[0].push_back(8'h01);
        rq[0].push_back(8'h02);
        drive_req();
        ex(1, 1, 8'h55, 2'd3, 4'b1000);
        ex(1, 0, 8'h00, 2'd3, 4'b1000);
        ex(0, 0, 8'h00, 2'd3, 4'b0000);
        ex(1, 1, 8'h01, 2'd0, 4'b0001);
        ex(1, 1, 8'h02, 2'd0, 4'b0001);
        ex(1, 0, 8'h00, 2'd0, 4'b0001);
        ex(0, 0, 8'h00, 2'd0, 4'b0000);
      end
      while (exp_q.size() != 0) begin
        step();
        e = exp_q.pop_front();
        checks++;
        if (obs !== e) begin
          failures++;
          $display("FAIL early_release: got %s, expected %s", fmt(obs), fmt(e));
        end
      end
    end
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    for (int k = 0; k < 3; k++) rq[0].push_back(8'(8'h70 + k));
    drive_req();
    ex(0, 0, 8'h00, 2'd0, 4'b0000);
    ex(1, 1, 8'h70, 2'd0, 4'b0001);
    while (exp_q.size() != 0) begin
      step();
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL reset_mid_pre: got %s, expected %s", fmt(obs), fmt(e));
      end
    end
    // Second beat (0x71) is presented and ready; pull reset between edges.
    #2;
    rst = 1'b0;
    #1;
    obs = sample();
    checks++;
    if (obs !== obs_t'(0)) begin
      failures++;
      $display("FAIL reset_mid_async: got %s, expected all zero", fmt(obs));
    end
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      obs = sample();
      checks++;
      if (obs !== obs_t'(0)) begin
        failures++;
        $display("FAIL reset_mid_held: got %s, expected all zero", fmt(obs));
      end
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    ex(0, 0, 8'h00, 2'd0, 4'b0000);
    ex(1, 1, 8'h71, 2'd0, 4'b0001);
    ex(1, 1, 8'h72, 2'd0, 4'b0001);
    ex(1, 0, 8'h00, 2'd0, 4'b0001);
    ex(0, 0, 8'h00, 2'd0, 4'b0000);
    while (exp_q.size() != 0) begin
      step();
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL reset_mid_post: got %s, expected %s", fmt(obs), fmt(e));
      end
    end
  endtask

  initial begin
    rst       = 1'b0;
    fifo_full = 1'b0;
    req_valid = '0;
    req_data  = '0;
    test_reset();
    test_single_burst();
    test_round_robin();
    test_full_stall();
    test_early_release();
    test_reset_mid_burst();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
